// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - registered, handshaked arbiter for the shared regfile write port
// Processor has priority in NORMAL; a starvation counter forces test grants; TEST_OWN gives the port to test.
module regfile_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             test,
    input  logic             p_valid,
    input  logic [4:0]       p_writeReg,
    input  logic [31:0]      p_data,
    output logic             p_ready,
    input  logic             t_valid,
    input  logic [4:0]       t_writeReg,
    input  logic [31:0]      t_data,
    output logic             t_ready,
    output logic             ctrl_writeEnable,
    output logic [4:0]       ctrl_writeReg,
    output logic [31:0]      data_writeReg,
    output logic             test_active,
    output logic [CNT_W-1:0] starve_grants
);

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        DRAIN    = 2'd1,
        TEST_OWN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_cnt_q, starve_cnt_d;
    logic [CNT_W-1:0]  grants_q, grants_d;
    logic              we_q, we_d;
    logic [4:0]        reg_q, reg_d;
    logic [31:0]       data_q, data_d;
    logic              force_grant;

    always_comb begin
        force_grant = (state_q == NORMAL) && (starve_cnt_q == LIMIT);
        p_ready     = 1'b0;
        t_ready     = 1'b0;
        case (state_q)
            NORMAL: begin
                p_ready = p_valid && !force_grant;
                t_ready = t_valid && (!p_valid || force_grant);
            end
            TEST_OWN: t_ready = t_valid;
            default: ;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        grants_d     = grants_q;
        we_d         = 1'b0;
        reg_d        = reg_q;
        data_d       = data_q;

        // Register 0 transfers are consumed but never reach the regfile.
        if (p_ready) begin
            we_d   = |p_writeReg;
            reg_d  = p_writeReg;
            data_d = p_data;
        end else if (t_ready) begin
            we_d   = |t_writeReg;
            reg_d  = t_writeReg;
            data_d = t_data;
        end

        case (state_q)
            NORMAL: begin
                if (test)
                    state_d = DRAIN;
                if (t_valid && !t_ready && starve_cnt_q != LIMIT)
                    starve_cnt_d = starve_cnt_q + 1'b1;
                else
                    starve_cnt_d = '0;
                if (force_grant && t_ready && grants_q != {CNT_W{1'b1}})
                    grants_d = grants_q + 1'b1;
            end
            DRAIN: begin
                // One idle cycle lets the last NORMAL write retire before test owns the port.
                if (test) begin
                    state_d      = TEST_OWN;
                    starve_cnt_d = '0;
                end else begin
                    state_d = NORMAL;
                end
            end
            TEST_OWN: begin
                starve_cnt_d = '0;
                if (!test)
                    state_d = NORMAL;
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= NORMAL;
            starve_cnt_q <= '0;
            grants_q     <= '0;
            we_q         <= 1'b0;
            reg_q        <= '0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            grants_q     <= grants_d;
            we_q         <= we_d;
            reg_q        <= reg_d;
            data_q       <= data_d;
        end
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = reg_q;
    assign data_writeReg    = data_q;
    assign test_active      = (state_q == TEST_OWN);
    assign starve_grants    = grants_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - directed bench with a behavioural arbitration model
// Model tracks mode, consecutive test losses and the expected output register.
module tb_regfile_write_arbiter;

    localparam int LIMIT = 4;
    localparam int CNT_W = 4;

    logic             clock = 1'b0;
    logic             reset;
    logic             test;
    logic             p_valid;
    logic [4:0]       p_writeReg;
    logic [31:0]      p_data;
    logic             p_ready;
    logic             t_valid;
    logic [4:0]       t_writeReg;
    logic [31:0]      t_data;
    logic             t_ready;
    logic             ctrl_writeEnable;
    logic [4:0]       ctrl_writeReg;
    logic [31:0]      data_writeReg;
    logic             test_active;
    logic [CNT_W-1:0] starve_grants;

    int vectors     = 0;
    int miscompares = 0;
    bit started     = 0;

    regfile_write_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .test(test),
        .p_valid(p_valid), .p_writeReg(p_writeReg), .p_data(p_data), .p_ready(p_ready),
        .t_valid(t_valid), .t_writeReg(t_writeReg), .t_data(t_data), .t_ready(t_ready),
        .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
        .data_writeReg(data_writeReg), .test_active(test_active),
        .starve_grants(starve_grants)
    );

    always #5 clock = ~clock;

    // Model: 0 = normal, 1 = drain, 2 = test owns the port.
    int          m_mode;
    int          m_losses;
    int          m_grants;
    logic        m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    function automatic logic exp_p_ready();
        return (m_mode == 0) && p_valid && (m_losses < LIMIT);
    endfunction

    function automatic logic exp_t_ready();
        if (m_mode == 2) return t_valid;
        if (m_mode == 0) return t_valid && (!p_valid || m_losses >= LIMIT);
        return 1'b0;
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_mode   <= 0;
            m_losses <= 0;
            m_grants <= 0;
            m_we     <= 1'b0;
            m_reg    <= '0;
            m_data   <= '0;
        end else begin
            if (exp_p_ready()) begin
                m_we <= (p_writeReg != 0); m_reg <= p_writeReg; m_data <= p_data;
            end else if (exp_t_ready()) begin
                m_we <= (t_writeReg != 0); m_reg <= t_writeReg; m_data <= t_data;
            end else begin
                m_we <= 1'b0;
            end
            if (m_mode == 0) begin
                m_losses <= (t_valid && !exp_t_ready()) ? m_losses + 1 : 0;
                if (t_valid && m_losses >= LIMIT && m_grants < 15)
                    m_grants <= m_grants + 1;
                m_mode <= test ? 1 : 0;
            end else if (m_mode == 1) begin
                if (test) m_losses <= 0;
                m_mode <= test ? 2 : 0;
            end else begin
                m_losses <= 0;
                m_mode   <= test ? 2 : 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (started && reset === 1'b0) begin
            chk("p_ready", 32'(p_ready), 32'(exp_p_ready()));
            chk("t_ready", 32'(t_ready), 32'(exp_t_ready()));
            chk("we", 32'(ctrl_writeEnable), 32'(m_we));
            chk("wreg", 32'(ctrl_writeReg), 32'(m_reg));
            chk("wdata", data_writeReg, m_data);
            chk("test_active", 32'(test_active), 32'(m_mode == 2));
            chk("starve_grants", 32'(starve_grants), 32'(m_grants));
        end
    end

    task automatic drive(input logic pv, input logic [4:0] pr, input logic [31:0] pd,
                         input logic tv, input logic [4:0] tr, input logic [31:0] td,
                         input logic ts);
        p_valid = pv; p_writeReg = pr; p_data = pd;
        t_valid = tv; t_writeReg = tr; t_data = td;
        test = ts;
        #2;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick();
        chk("rst_we", 32'(ctrl_writeEnable), 0);
        chk("rst_reg", 32'(ctrl_writeReg), 0);
        chk("rst_data", data_writeReg, 0);
        chk("rst_active", 32'(test_active), 0);
        chk("rst_grants", 32'(starve_grants), 0);
        reset = 1'b0;
        started = 1;
        tick();

        // Reset between acceptance and the output edge drops the write.
        drive(1, 5, 32'h11, 0, 0, 0, 0);
        chk("mid_p_ready", 32'(p_ready), 1);
        reset = 1'b1;
        tick();
        chk("mid_we", 32'(ctrl_writeEnable), 0);
        chk("mid_reg", 32'(ctrl_writeReg), 0);
        chk("mid_data", data_writeReg, 0);
        chk("mid_grants", 32'(starve_grants), 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        tick();

        // Priority.
        drive(1, 3, 32'hAAAA, 1, 4, 32'hBBBB, 0);
        chk("pri_p_ready", 32'(p_ready), 1);
        chk("pri_t_ready", 32'(t_ready), 0);
        tick();
        chk("pri_we", 32'(ctrl_writeEnable), 1);
        chk("pri_reg", 32'(ctrl_writeReg), 3);
        chk("pri_data", data_writeReg, 32'hAAAA);
        idle();

        // Starvation: four losses then a forced grant.
        for (int i = 1; i <= 5; i++) begin
            drive(1, 2, 32'h22, 1, 7, 32'h1234, 0);
            chk("stv_t_ready", 32'(t_ready), (i == 5) ? 1 : 0);
            chk("stv_p_ready", 32'(p_ready), (i == 5) ? 0 : 1);
            tick();
        end
        chk("stv_reg", 32'(ctrl_writeReg), 7);
        chk("stv_data", data_writeReg, 32'h1234);
        chk("stv_grants", 32'(starve_grants), 1);
        drive(1, 2, 32'h22, 1, 8, 32'h5678, 0);
        chk("stv_cnt_clear", 32'(t_ready), 0);
        tick();
        idle();

        // Register 0.
        drive(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0);
        chk("r0_t_ready", 32'(t_ready), 1);
        tick();
        chk("r0_we", 32'(ctrl_writeEnable), 0);
        idle();

        // Same-register writes in order.
        drive(1, 6, 32'h1, 0, 0, 0, 0);
        tick();
        chk("same1_data", data_writeReg, 32'h1);
        drive(1, 6, 32'h2, 0, 0, 0, 0);
        tick();
        chk("same2_we", 32'(ctrl_writeEnable), 1);
        chk("same2_data", data_writeReg, 32'h2);
        idle();

        // Mode switch.
        drive(1, 10, 32'h100, 0, 0, 0, 1);
        chk("ms_p_ready", 32'(p_ready), 1);
        tick();
        chk("ms_reg10", 32'(ctrl_writeReg), 10);
        drive(1, 11, 32'h101, 1, 9, 32'h55, 1);
        chk("ms_drain_p", 32'(p_ready), 0);
        chk("ms_drain_t", 32'(t_ready), 0);
        chk("ms_drain_act", 32'(test_active), 0);
        tick();
        chk("ms_drain_we", 32'(ctrl_writeEnable), 0);
        chk("ms_own_act", 32'(test_active), 1);
        chk("ms_own_p", 32'(p_ready), 0);
        chk("ms_own_t", 32'(t_ready), 1);
        tick();
        chk("ms_t_reg", 32'(ctrl_writeReg), 9);
        chk("ms_t_data", data_writeReg, 32'h55);
        drive(1, 11, 32'h101, 0, 0, 0, 0);
        chk("ms_exit_act", 32'(test_active), 1);
        chk("ms_exit_p", 32'(p_ready), 0);
        tick();
        chk("ms_norm_act", 32'(test_active), 0);
        chk("ms_norm_p", 32'(p_ready), 1);
        tick();
        chk("ms_p_reg", 32'(ctrl_writeReg), 11);
        idle();

        // One-cycle test glitch.
        drive(1, 12, 32'h200, 0, 0, 0, 1);
        tick();
        drive(1, 13, 32'h201, 0, 0, 0, 0);
        chk("gl_drain_p", 32'(p_ready), 0);
        tick();
        chk("gl_drain_we", 32'(ctrl_writeEnable), 0);
        chk("gl_active", 32'(test_active), 0);
        chk("gl_p_ready", 32'(p_ready), 1);
        tick();
        chk("gl_reg13", 32'(ctrl_writeReg), 13);
        chk("gl_data", data_writeReg, 32'h201);
        idle();

        // Saturation of the forced-grant count.
        for (int i = 0; i < 80; i++) begin
            drive(1, 1, 32'h77, 1, 2, 32'h88, 0);
            tick();
        end
        chk("sat_grants", 32'(starve_grants), 15);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
